key_press_sequencer: RTL and testbench
======================================

// Module: key_press_sequencer
// PURPOSE
//  Key-stimulus generator for the two-key up/down speed counter. Given a target value,
//  it emits timed press/release sequences on the same two key lines the counter samples.
//  The counter's current value is fed back, and the counter is stepped until it equals
//  the target.
//  Drives the counter from a controller or testbench in place of a human on the keys.
// PARAMETERS
//  WIDTH        4   counter/target width in bits
//  HOLD_CYCLES  4   clock cycles a key stays pressed per step (>=2)
//  GAP_CYCLES   4   clock cycles both keys stay released between steps (>=2)
//  MAX_STEPS    17  steps allowed before error abort (default 2**WIDTH+1)
// PORTS
//  clock     in   1      single clock; all logic on rising edge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  target    in   WIDTH  desired counter value; latched when start is accepted
//  count_fb  in   WIDTH  current counter value fed back from the counter
//  Key2      out  1      up key, active-low (0 = pressed)
//  Key1      out  1      down key, active-low (0 = pressed)
//  busy      out  1      high from acceptance until DONE/ERR is exited
//  done      out  1      one-cycle pulse: count_fb == target reached
//  error     out  1      one-cycle pulse: step budget exhausted or no progress
// BEHAVIOUR
//  Reset values
//   - Key2 = Key1 = 1 (released); busy = done = error = 0; FSM in IDLE.
//   - Step and timer counters are cleared.
//   - Reset mid-press releases both keys on the next edge.
//  Key encoding (registered outputs only, never combinational)
//   - Idle:       Key2=1, Key1=1
//   - Up press:   Key2=0, Key1=1
//   - Down press: Key2=1, Key1=0
//   - Both=0 is never driven.
//  FSM states: IDLE, EVAL, PRESS, RELEASE, DONE, ERR
//   - IDLE: if start, latch target into tgt_q, clear steps and timer, go to EVAL.
//     busy rises one cycle after start.
//   - EVAL (1 cycle, keys released):
//     - count_fb == tgt_q: go to DONE.
//     - steps == MAX_STEPS: go to ERR.
//     - Otherwise latch dir_q = (count_fb < tgt_q), snapshot count_fb into prev_q,
//       increment steps, go to PRESS.
//   - PRESS: drive the key selected by dir_q for exactly HOLD_CYCLES cycles, then go
//     to RELEASE.
//   - RELEASE: both keys = 1 for exactly GAP_CYCLES cycles.
//     - At the last gap cycle, if count_fb == prev_q (counter did not move), go to ERR.
//     - Otherwise go to EVAL.
//   - DONE: done = 1 for one cycle, busy = 0, then IDLE.
//   - ERR: error = 1 for one cycle, busy = 0, then IDLE.
//  Rules
//   - start while busy is ignored; target changes after acceptance are ignored.
//   - Magnitude compare is unsigned; no wrap-around is commanded (0->15 is 15 up steps).
//   - An already-equal target gives done 2 cycles after start (IDLE->EVAL->DONE) with
//     no key activity.
//   - Timing per step: 1 EVAL + HOLD_CYCLES + GAP_CYCLES cycles.
//   - Latency from start to done = 2 + N*(1+HOLD_CYCLES+GAP_CYCLES) cycles for N steps.
//   - Timer width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1); step counter width is
//     clog2(MAX_STEPS+1).
// STRUCTURE
//  Shared package key_seq_pkg
//   - State enumeration localparams (3-bit user encoding, IDLE=0).
//   - Key encoding constants KEY_IDLE, KEY_UP, KEY_DOWN as 2-bit {Key2, Key1}.
//  Sub-module key_seq_timer
//   - Loadable down-counter with terminal-count flag, shared by PRESS and RELEASE.
//  Top level holds the FSM, tgt_q, dir_q, prev_q and the step counter.
// TESTING (bench instantiates the up/down speed counter as DUT partner, Key lines
// wired direct)
//  1. Reset, count=0, start with target=5: exactly 5 up presses, Key1 stays 1, done
//     pulses once, count_fb=5 at done.
//  2. From count=9, target=3: 6 down presses, Key2 stays 1, done; latency =
//     2+6*9 = 56 cycles with defaults.
//  3. target equal to count (7 -> 7): no key goes low; done 2 cycles after start.
//  4. Extremes 0 -> 15 then 15 -> 0: 15 steps each, no wrap; counter holds at the ends.
//  5. Stuck feedback (count_fb tied to 4, target 10): error after first step, busy drops.
//  6. Assert reset in the middle of PRESS: keys both 1 next cycle, busy=0. start
//     pulsed while busy is ignored.

Source files
------------

// File: rtl/key_seq_pkg.sv
// Shared types and constants for the key press sequencer: FSM state encoding,
// active-low key patterns and a small sizing helper.
package key_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EVAL    = 3'd1,
    S_PRESS   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  // {Key2, Key1}, active-low; both-low is never produced
  localparam logic [1:0] KEY_IDLE = 2'b11;
  localparam logic [1:0] KEY_UP   = 2'b01;
  localparam logic [1:0] KEY_DOWN = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_seq_timer.sv
// Loadable down-counter with terminal-count flag; times both the key hold
// and the release gap.
module key_seq_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/key_press_sequencer.sv
// Steps an up/down key counter toward a latched target by emitting timed
// press/release sequences and watching the counter's fed-back value.
module key_press_sequencer
  import key_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_STEPS   = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] count_fb,
  output logic             Key2,
  output logic             Key1,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int TW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);

  state_t           state_q, state_next;
  logic [WIDTH-1:0] tgt_q, prev_q;
  logic             dir_q, dir_next;
  logic [SW-1:0]    steps_q;
  logic [1:0]       keys_q;
  logic             busy_q, done_q, error_q;

  logic             accept, step_take;
  logic             timer_load, timer_tc;
  logic [TW-1:0]    timer_value;

  key_seq_timer #(.WIDTH(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .tc    (timer_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next  = state_q;
    accept      = 1'b0;
    step_take   = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    dir_next    = (count_fb < tgt_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (count_fb == tgt_q) begin
          state_next = S_DONE;
        end else if (steps_q == STEP_LIMIT) begin
          state_next = S_ERR;
        end else begin
          step_take   = 1'b1;
          timer_load  = 1'b1;
          timer_value = HOLD_LOAD;
          state_next  = S_PRESS;
        end
      end
      S_PRESS: begin
        if (timer_tc) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
          state_next  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // A counter that did not move during this step will never converge
        if (timer_tc) begin
          state_next = (count_fb == prev_q) ? S_ERR : S_EVAL;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tgt_q   <= '0;
      prev_q  <= '0;
      dir_q   <= 1'b0;
      steps_q <= '0;
    end else begin
      if (accept) begin
        tgt_q   <= target;
        steps_q <= '0;
      end
      if (step_take) begin
        dir_q   <= dir_next;
        prev_q  <= count_fb;
        steps_q <= steps_q + SW'(1);
      end
    end
  end

  // Outputs are registered from the next state so they align with the state cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      keys_q  <= KEY_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (state_next == S_PRESS) begin
        keys_q <= (step_take ? dir_next : dir_q) ? KEY_UP : KEY_DOWN;
      end else begin
        keys_q <= KEY_IDLE;
      end
      busy_q  <= (state_next == S_EVAL) || (state_next == S_PRESS) ||
                 (state_next == S_RELEASE);
      done_q  <= (state_next == S_DONE);
      error_q <= (state_next == S_ERR);
    end
  end

  assign Key2  = keys_q[1];
  assign Key1  = keys_q[0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_key_press_sequencer.sv
// Bench for key_press_sequencer: a behavioural up/down counter closes the loop,
// directed and random transactions are checked against step/latency arithmetic.
module tb_key_press_sequencer;

  localparam int H    = 4;
  localparam int G    = 4;
  localparam int STEP = 1 + H + G;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [3:0] target, count_fb;
  logic       Key2, Key1, busy, done, error;

  logic [3:0] cnt = 4'd0;
  logic       prev2 = 1'b1, prev1 = 1'b1;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  key_press_sequencer #(
    .WIDTH(4), .HOLD_CYCLES(H), .GAP_CYCLES(G), .MAX_STEPS(17)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .target   (target),
    .count_fb (count_fb),
    .Key2     (Key2),
    .Key1     (Key1),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  // Partner counter: steps once per key press, saturates at 0 and 15
  assign count_fb = stuck ? 4'd4 : cnt;
  always @(posedge clock) begin
    prev2 <= Key2;
    prev1 <= Key1;
    if (load_en) cnt <= load_val;
    else if (prev2 && !Key2 && cnt != 4'd15) cnt <= cnt + 4'd1;
    else if (prev1 && !Key1 && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input string name, input int init, input int tgt,
                     input bit stk, input bit poke);
    int n, exp_up, exp_dn, exp_lat, cyc, ups, downs, up_low, dn_low, both;
    logic p2, p1, fin_done, fin_err;
    @(negedge clock);
    load_en = 1'b1; load_val = init[3:0]; stuck = stk;
    @(negedge clock);
    load_en = 1'b0; target = tgt[3:0]; start = 1'b1;
    @(negedge clock);
    start = 1'b0; target = 4'($urandom);
    check({name, "_busy_rise"}, busy, 1);
    cyc = 1; ups = 0; downs = 0; up_low = 0; dn_low = 0; both = 0;
    p2 = 1'b1; p1 = 1'b1; fin_done = 1'b0; fin_err = 1'b0;
    while (cyc < 400) begin
      if (poke && cyc == 3) begin start = 1'b1; target = 4'd0; end
      if (poke && cyc == 4) start = 1'b0;
      if (!Key2 && !Key1) both++;
      if (!Key2) up_low++;
      if (!Key1) dn_low++;
      if (p2 && !Key2) ups++;
      if (p1 && !Key1) downs++;
      p2 = Key2; p1 = Key1;
      if (done || error) begin fin_done = done; fin_err = error; break; end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    n       = stk ? 1 : ((tgt > init) ? tgt - init : init - tgt);
    exp_up  = (tgt > init) ? n : 0;
    exp_dn  = (tgt < init) ? n : 0;
    exp_lat = stk ? 1 + STEP : 2 + n * STEP;
    check({name, "_done"}, fin_done, !stk);
    check({name, "_error"}, fin_err, stk);
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_up_presses"}, ups, exp_up);
    check({name, "_down_presses"}, downs, exp_dn);
    check({name, "_up_hold"}, up_low, exp_up * H);
    check({name, "_down_hold"}, dn_low, exp_dn * H);
    check({name, "_both_low"}, both, 0);
    check({name, "_busy_at_end"}, busy, 0);
    if (!stk) check({name, "_final_count"}, count_fb, tgt);
    @(negedge clock);
    check({name, "_pulse_one_cycle"}, {done, error}, 0);
    $display("txn %s: %0d -> %0d stuck=%0d cycles=%0d up=%0d down=%0d",
             name, init, tgt, stk, cyc, ups, downs);
    stuck = 1'b0;
  endtask

  initial begin
    int wait_cyc;
    reset = 1'b1; start = 1'b0; target = 4'd0;
    repeat (3) @(negedge clock);
    check("reset_keys", {Key2, Key1}, 2'b11);
    check("reset_flags", {busy, done, error}, 3'b000);
    reset = 1'b0;

    run("up_0_5", 0, 5, 1'b0, 1'b0);
    run("down_9_3", 9, 3, 1'b0, 1'b0);
    run("equal_7", 7, 7, 1'b0, 1'b0);
    run("ext_0_15", 0, 15, 1'b0, 1'b0);
    run("ext_15_0", 15, 0, 1'b0, 1'b0);
    run("stuck_4_10", 4, 10, 1'b1, 1'b0);
    run("start_while_busy", 2, 6, 1'b0, 1'b1);

    // Reset in the middle of a press
    @(negedge clock);
    load_en = 1'b1; load_val = 4'd0;
    @(negedge clock);
    load_en = 1'b0; target = 4'd12; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_cyc = 0;
    while (Key2 && wait_cyc < 20) begin @(negedge clock); wait_cyc++; end
    check("midpress_key_seen", Key2, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midpress_keys_released", {Key2, Key1}, 2'b11);
    check("midpress_busy_low", busy, 0);
    reset = 1'b0;
    $display("txn midpress_reset: keys=%b busy=%0d", {Key2, Key1}, busy);

    for (int i = 0; i < 8; i++) begin
      run($sformatf("rand%0d", i), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
